// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the clkdiv_multi divider.
// Holds the minimum divisor, the divisor clamp and the channel-index width.
package clkdiv_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Divisors below MIN_DIV cannot form a square wave; raise them.
    function automatic logic [63:0] clamp_div(input logic [63:0] d);
        return (d < 64'(MIN_DIV)) ? 64'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if: valid/ready divisor configuration port.
// master drives a write request, slave (the divider) answers with cfg_ready.
interface clkdiv_multi_if
    import clkdiv_pkg::*;
#(
    parameter int WIDTH    = 25,
    parameter int CHANNELS = 2
);
    localparam int CW = chan_w(CHANNELS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [WIDTH-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider slice (counter, active/shadow divisor, pending).
// sync input is honoured only when CLKDIV_SYNC_EN is defined.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int          WIDTH       = 25,
    parameter int unsigned DEFAULT_DIV = 500
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_div,
    output logic             pending,
    output logic             clock_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] div_active;
    logic [WIDTH-1:0] div_shadow;
    logic             wrap;
    logic             high;
    logic             do_sync;

`ifdef CLKDIV_SYNC_EN
    assign do_sync = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign do_sync     = 1'b0;
`endif

    assign wrap = counter >= (div_active - WIDTH'(1));
    assign high = counter < (div_active >> 1);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            counter    <= '0;
            div_active <= DIV_RST;
            div_shadow <= DIV_RST;
            pending    <= 1'b0;
            clock_out  <= 1'b0;
            tick       <= 1'b0;
        end else begin
            if (enable)
                clock_out <= high;
            // Divisor swaps only here, so counter never exceeds div_active-1.
            if (do_sync || (enable && wrap)) begin
                counter <= '0;
                tick    <= 1'b1;
                if (pending) begin
                    div_active <= div_shadow;
                    pending    <= 1'b0;
                end
            end else begin
                if (enable)
                    counter <= counter + WIDTH'(1);
                tick <= 1'b0;
            end
            // A write landing on a wrap stays pending for the next one.
            if (wr_en) begin
                div_shadow <= wr_div;
                pending    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: runtime-programmable multi-channel glitch-free clock divider.
// Define CLKDIV_SYNC_EN to make sync_req realign all channels to phase 0.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int          WIDTH       = 25,
    parameter int          CHANNELS    = 2,
    parameter int unsigned DEFAULT_DIV = 500
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                sync_req,
    clkdiv_multi_if.slave       cfg,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick
);

    localparam int CW = chan_w(CHANNELS);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_en;
    logic [WIDTH-1:0]    div_c;
    logic                ready_c;

    assign div_c = WIDTH'(clamp_div(64'(cfg.cfg_div)));

    // Out-of-range channels match nothing: always ready, write dropped.
    always_comb begin
        ready_c = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg.cfg_chan == CW'(i))
                ready_c = !pending[i];
        end
    end

    assign cfg.cfg_ready = ready_c;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_en[i] = cfg.cfg_valid && ready_c
                    && (cfg.cfg_chan == CW'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clkdiv_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock_in  (clock_in),
            .reset_n   (reset_n),
            .enable    (enable),
            .sync      (sync_req),
            .wr_en     (wr_en[g]),
            .wr_div    (div_c),
            .pending   (pending[g]),
            .clock_out (clock_out[g]),
            .tick      (tick[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: scoreboard bench for clkdiv_multi (3 channels, div 500).
// Sync scenario follows CLKDIV_SYNC_EN.
module tb_clkdiv_multi;
    import clkdiv_pkg::*;

    localparam int W  = 25;
    localparam int N  = 3;
    localparam int DD = 500;

    typedef struct packed {
        logic [N-1:0] co;
        logic [N-1:0] tk;
        logic         rdy;
    } exp_t;

    logic         clock_in = 1'b0;
    logic         reset_n  = 1'b0;
    logic         enable;
    logic         sync_req;
    logic [N-1:0] clock_out;
    logic [N-1:0] tick;
    logic         rdy_obs;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t        sb[$];
    int unsigned m_cnt[N];
    int unsigned m_act[N];
    int unsigned m_shd[N];
    bit          m_pend[N];
    logic [N-1:0] m_co;
    logic [N-1:0] m_tk;

    clkdiv_multi_if #(.WIDTH(W), .CHANNELS(N)) cfg_bus ();

    clkdiv_multi #(
        .WIDTH       (W),
        .CHANNELS    (N),
        .DEFAULT_DIV (DD)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .enable    (enable),
        .sync_req  (sync_req),
        .cfg       (cfg_bus),
        .clock_out (clock_out),
        .tick      (tick)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, limit 1ms");
        $fatal(1);
    end

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_cnt[c]  = 0;
            m_act[c]  = DD;
            m_shd[c]  = DD;
            m_pend[c] = 1'b0;
        end
        m_co = '0;
        m_tk = '0;
    endtask

    // Predict the next edge from the inputs now applied, queue it, then clock.
    task automatic clk_step();
        exp_t e;
        bit   in_rng;
        bit   acc;
        bit   sy;
        int   ch;
        #1;
        rdy_obs = cfg_bus.cfg_ready;
        ch      = int'(cfg_bus.cfg_chan);
        in_rng  = ch < N;
        e.rdy   = 1'b1;
        if (in_rng) e.rdy = !m_pend[ch];
        acc = cfg_bus.cfg_valid && e.rdy && in_rng;
`ifdef CLKDIV_SYNC_EN
        sy = sync_req;
`else
        sy = 1'b0;
`endif
        for (int c = 0; c < N; c++) begin
            if (enable) m_co[c] = m_cnt[c] < m_act[c] / 2;
            if (sy || (enable && m_cnt[c] + 1 >= m_act[c])) begin
                m_cnt[c] = 0;
                m_tk[c]  = 1'b1;
                if (m_pend[c]) begin
                    m_act[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end
            end else begin
                if (enable) m_cnt[c]++;
                m_tk[c] = 1'b0;
            end
            if (acc && c == ch) begin
                m_shd[c]  = (cfg_bus.cfg_div < 2) ? 2 : int'(cfg_bus.cfg_div);
                m_pend[c] = 1'b1;
            end
        end
        e.co = m_co;
        e.tk = m_tk;
        sb.push_back(e);
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        enable            = 1'b1;
        sync_req          = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        int hi = 0;
        int nt = 0;
        reset_n  = 1'b0;
        enable   = 1'b1;
        sync_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_in);
            #1;
            n_chk++;
            if (clock_out !== '0 || tick !== '0 || cfg_bus.cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold: co=%b tk=%b rdy=%b, want 000 000 1",
                         clock_out, tick, cfg_bus.cfg_ready);
            end
        end
        reset_n = 1'b1;
        model_reset();
        sb.delete();
        for (int i = 1; i <= 1000; i++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL reset_run @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         i, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
            if (i == 1) begin
                n_chk++;
                if (clock_out[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_edge: co0=%b, want 1", clock_out[0]);
                end
            end
            if (i <= 500 && clock_out[0] === 1'b1) hi++;
            if (tick[0] === 1'b1) nt++;
        end
        n_chk++;
        if (hi != 250) begin
            n_fail++;
            $display("FAIL default_high: %0d high cycles, want 250", hi);
        end
        n_chk++;
        if (nt != 2) begin
            n_fail++;
            $display("FAIL default_ticks: %0d ticks in 1000, want 2", nt);
        end
    endtask

    task automatic test_cfg_latency();
        exp_t e;
        int t1[$];
        int n0 = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL lat_pre @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         i, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
        end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_chan  = 2'd1;
        cfg_bus.cfg_div   = W'(4);
        clk_step();
        e = sb.pop_front();
        cfg_bus.cfg_valid = 1'b0;
        n_chk++;
        if (rdy_obs !== 1'b1 || clock_out !== e.co || tick !== e.tk) begin
            n_fail++;
            $display("FAIL lat_write: rdy=%b co=%b tk=%b, want 1 %b %b",
                     rdy_obs, clock_out, tick, e.co, e.tk);
        end
        for (int j = 1; j <= 420; j++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL lat_run @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         j, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
            if (tick[1] === 1'b1) t1.push_back(j);
            if (tick[0] === 1'b1) n0++;
        end
        n_chk++;
        if (t1.size() < 3) begin
            n_fail++;
            $display("FAIL lat_ticks: %0d ch1 ticks, want >= 3", t1.size());
        end else begin
            n_chk++;
            if (t1[0] != 399 || t1[1] - t1[0] != 4 || t1[2] - t1[1] != 4) begin
                n_fail++;
                $display("FAIL lat_period: ch1 ticks %0d %0d %0d, want 399 403 407",
                         t1[0], t1[1], t1[2]);
            end
        end
        n_chk++;
        if (n0 != 1) begin
            n_fail++;
            $display("FAIL lat_ch0: %0d ch0 ticks, want 1", n0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int  stalls = 0;
        bit  acc = 1'b0;
        bit  saw = 1'b0;
        int  tk[$];
        int  hi5 = 0;
        int  hi7 = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            clk_step();
            e = sb.pop_front();
        end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_chan  = 2'd0;
        cfg_bus.cfg_div   = W'(5);
        clk_step();
        e = sb.pop_front();
        n_chk++;
        if (rdy_obs !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: rdy=%b, want 1", rdy_obs);
        end
        cfg_bus.cfg_div = W'(7);
        for (int k = 0; k < 600 && !acc; k++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL b2b_stall @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         k, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
            if (rdy_obs === 1'b1) begin
                acc = 1'b1;
                n_chk++;
                if (!saw) begin
                    n_fail++;
                    $display("FAIL b2b_early: accepted before wrap, want after");
                end
            end else begin
                stalls++;
            end
            if (tick[0] === 1'b1) saw = 1'b1;
        end
        cfg_bus.cfg_valid = 1'b0;
        n_chk++;
        if (!acc || stalls != 489) begin
            n_fail++;
            $display("FAIL b2b_stalls: acc=%0d stalls=%0d, want 1 489", acc, stalls);
        end
        for (int j = 1; j <= 20; j++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL b2b_run @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         j, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
            if (tick[0] === 1'b1) tk.push_back(j);
            if (j <= 4 && clock_out[0] === 1'b1) hi5++;
            if (j >= 5 && j <= 11 && clock_out[0] === 1'b1) hi7++;
        end
        n_chk++;
        if (tk.size() < 2 || tk[0] != 4 || tk[1] != 11) begin
            n_fail++;
            $display("FAIL b2b_period: %0d ticks, want ticks at 4 and 11", tk.size());
        end
        n_chk++;
        if (hi5 != 1 || hi7 != 3) begin
            n_fail++;
            $display("FAIL b2b_duty: high %0d/%0d, want 1/3", hi5, hi7);
        end
    endtask

    task automatic test_clamp_range();
        exp_t e;
        int t0[$];
        int n12 = 0;
        int hi  = 0;
        do_reset();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_chan  = 2'd3;
        cfg_bus.cfg_div   = W'(9);
        clk_step();
        e = sb.pop_front();
        cfg_bus.cfg_chan = 2'd0;
        cfg_bus.cfg_div  = '0;
        clk_step();
        e = sb.pop_front();
        cfg_bus.cfg_chan = 2'd3;
        cfg_bus.cfg_div  = W'(1);
        clk_step();
        e = sb.pop_front();
        n_chk++;
        if (rdy_obs !== 1'b1) begin
            n_fail++;
            $display("FAIL range_ready: rdy=%b for chan 3, want 1", rdy_obs);
        end
        cfg_bus.cfg_valid = 1'b0;
        for (int j = 1; j <= 520; j++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL clamp_run @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         j, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
            if (tick[0] === 1'b1) t0.push_back(j);
            if (tick[1] === 1'b1 || tick[2] === 1'b1) n12++;
            if (j >= 498 && j <= 517 && clock_out[0] === 1'b1) hi++;
        end
        n_chk++;
        if (t0.size() < 3 || t0[0] != 497 || t0[1] != 499 || t0[2] != 501) begin
            n_fail++;
            $display("FAIL clamp_period: %0d ch0 ticks, want 497 499 501 ...", t0.size());
        end
        n_chk++;
        if (hi != 10) begin
            n_fail++;
            $display("FAIL clamp_duty: high %0d of 20, want 10", hi);
        end
        n_chk++;
        if (n12 != 1) begin
            n_fail++;
            $display("FAIL range_drop: ch1/ch2 tick cycles %0d, want 1", n12);
        end
    endtask

    task automatic test_enable_freeze();
        exp_t e;
        int first = -1;
        do_reset();
        for (int i = 0; i < 123; i++) begin
            clk_step();
            e = sb.pop_front();
        end
        enable = 1'b0;
        for (int j = 1; j <= 37; j++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== 3'b111 || tick !== 3'b000 || clock_out !== e.co) begin
                n_fail++;
                $display("FAIL freeze @%0d: co=%b tk=%b, want 111 000", j, clock_out, tick);
            end
        end
        enable = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL resume @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         j, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
            if (first < 0 && tick[0] === 1'b1) first = j;
        end
        n_chk++;
        if (first != 377) begin
            n_fail++;
            $display("FAIL resume_wrap: first tick at %0d, want 377", first);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int first = -1;
        int n2 = 0;
        do_reset();
        for (int i = 0; i < 77; i++) begin
            clk_step();
            e = sb.pop_front();
        end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_chan  = 2'd2;
        cfg_bus.cfg_div   = W'(3);
        clk_step();
        e = sb.pop_front();
        cfg_bus.cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_step();
            e = sb.pop_front();
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (clock_out !== '0 || tick !== '0 || cfg_bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: co=%b tk=%b rdy=%b, want 000 000 1",
                     clock_out, tick, cfg_bus.cfg_ready);
        end
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;
        model_reset();
        sb.delete();
        for (int j = 1; j <= 510; j++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL post_reset @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         j, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
            if (tick[2] === 1'b1) begin
                n2++;
                if (first < 0) first = j;
            end
        end
        n_chk++;
        if (n2 != 1 || first != 500) begin
            n_fail++;
            $display("FAIL pending_lost: ch2 ticks %0d first %0d, want 1 at 500", n2, first);
        end
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync();
        exp_t e;
        int dv[N];
        dv[0] = 10;
        dv[1] = 13;
        dv[2] = 6;
        do_reset();
        for (int c = 0; c < N; c++) begin
            cfg_bus.cfg_valid = 1'b1;
            cfg_bus.cfg_chan  = 2'(c);
            cfg_bus.cfg_div   = W'(dv[c]);
            clk_step();
            e = sb.pop_front();
        end
        cfg_bus.cfg_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            sync_req = 1'b1;
            clk_step();
            e = sb.pop_front();
            sync_req = 1'b0;
            n_chk++;
            if (tick !== 3'b111 || tick !== e.tk || clock_out !== e.co) begin
                n_fail++;
                $display("FAIL sync_tick r%0d: tk=%b co=%b, want 111 %b", r, tick, clock_out, e.co);
            end
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== 3'b111 || tick !== e.tk) begin
                n_fail++;
                $display("FAIL sync_align r%0d: co=%b tk=%b, want 111 %b", r, clock_out, tick, e.tk);
            end
            for (int j = 1; j <= 17; j++) begin
                clk_step();
                e = sb.pop_front();
                n_chk++;
                if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                    n_fail++;
                    $display("FAIL sync_run @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                             j, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
                end
            end
        end
        sync_req = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (clock_out !== '0 || tick !== '0) begin
            n_fail++;
            $display("FAIL sync_reset: co=%b tk=%b, want 000 000", clock_out, tick);
        end
        @(posedge clock_in);
        #1;
        reset_n  = 1'b1;
        sync_req = 1'b0;
        model_reset();
        sb.delete();
        for (int j = 1; j <= 5; j++) begin
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || rdy_obs !== e.rdy) begin
                n_fail++;
                $display("FAIL sync_post @%0d: co=%b tk=%b rdy=%b, want %b %b %b",
                         j, clock_out, tick, rdy_obs, e.co, e.tk, e.rdy);
            end
        end
    endtask
`else
    task automatic test_sync();
        exp_t e;
        do_reset();
        for (int j = 1; j <= 50; j++) begin
            sync_req = (j >= 20 && j <= 22);
            clk_step();
            e = sb.pop_front();
            n_chk++;
            if (clock_out !== e.co || tick !== e.tk || tick !== 3'b000) begin
                n_fail++;
                $display("FAIL sync_ignored @%0d: co=%b tk=%b, want %b 000",
                         j, clock_out, tick, e.co);
            end
        end
        sync_req = 1'b0;
    endtask
`endif

    initial begin
        enable            = 1'b1;
        sync_req          = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_chan  = '0;
        cfg_bus.cfg_div   = '0;
        test_reset();
        test_cfg_latency();
        test_back_to_back();
        test_clamp_range();
        test_enable_freeze();
        test_async_reset();
        test_sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
